// File: rtl/proc_controller.sv
// Purpose : control FSM sequencing the 9-bit register/ALU datapath (GPRs, A, G, add/sub, bus mux, IR).
// Latency : mv/mvi/no-op finish 2 cycles after the fetch cycle with run=1 (done inclusive); add/sub take 4.
// Backpressure: none; run is only sampled in T0, so a held run gives back-to-back instructions.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous active-high; forces T0 and all outputs low
//   run      in   1  start request, sampled in T0
//   ir       in   9  IR contents from the datapath: [8:6] opcode, [5:3] X, [2:0] Y
//   r_in     out  8  GPR load enables (one-hot or zero)
//   r_out    out  8  GPR bus-drive selects (one-hot or zero)
//   a_in     out  1  load A from bus
//   g_in     out  1  load G from adder result
//   g_out    out  1  G drives bus
//   din_out  out  1  din drives bus
//   ir_in    out  1  load IR from din
//   addsub   out  1  0 = add, 1 = subtract
//   done     out  1  one-cycle pulse in the final cycle of an instruction
//   busy     out  1  high in T1..T3
module proc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [8:0] ir,
    output logic [7:0] r_in,
    output logic [7:0] r_out,
    output logic       a_in,
    output logic       g_in,
    output logic       g_out,
    output logic       din_out,
    output logic       ir_in,
    output logic       addsub,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t state;
    state_t state_nxt;

    logic [2:0] opcode;
    logic [7:0] x_sel;
    logic [7:0] y_sel;

    assign opcode = ir[8:6];

    // Register fields decoded to one-hot so every enable/select is one-hot by construction.
    assign x_sel = 8'b0000_0001 << ir[5:3];
    assign y_sel = 8'b0000_0001 << ir[2:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= T0;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are purely combinational from state/ir/run. The async reset forces
    // state to T0 with run gated off, so every output drops low immediately.
    always_comb begin
        state_nxt = state;
        r_in      = 8'h00;
        r_out     = 8'h00;
        a_in      = 1'b0;
        g_in      = 1'b0;
        g_out     = 1'b0;
        din_out   = 1'b0;
        ir_in     = 1'b0;
        addsub    = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;

        unique case (state)
            T0: begin
                // IR is only loaded here, which keeps it stable through execute.
                ir_in = run & ~reset;
                if (run) begin
                    state_nxt = T1;
                end
            end

            T1: begin
                busy = 1'b1;
                case (opcode)
                    OP_MV: begin
                        r_out     = y_sel;
                        r_in      = x_sel;
                        done      = 1'b1;
                        state_nxt = T0;
                    end
                    OP_MVI: begin
                        din_out   = 1'b1;
                        r_in      = x_sel;
                        done      = 1'b1;
                        state_nxt = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        r_out     = x_sel;
                        a_in      = 1'b1;
                        state_nxt = T2;
                    end
                    default: begin
                        // Unused opcodes retire as a no-op with no enables.
                        done      = 1'b1;
                        state_nxt = T0;
                    end
                endcase
            end

            T2: begin
                busy      = 1'b1;
                r_out     = y_sel;
                g_in      = 1'b1;
                // Opcode LSB distinguishes sub (011) from add (010).
                addsub    = ir[6];
                state_nxt = T3;
            end

            T3: begin
                busy      = 1'b1;
                g_out     = 1'b1;
                r_in      = x_sel;
                done      = 1'b1;
                state_nxt = T0;
            end

            default: begin
                state_nxt = T0;
            end
        endcase
    end

endmodule
